// File: rtl/mlab_fifo_pkg.sv
// Shared types and helpers for the MLAB FIFO read-side controller.
// Occupancy type, skid depth and Gray encoding used by mlab_fifo_reader.
package mlab_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/mlab_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
// Each binary bit is the XOR of all Gray bits at or above it.
module mlab_gray2bin #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/mlab_fifo_reader.sv
// Read-side controller of the dual-clock MLAB buffer, rclk domain only.
// Optional registered fill level under macro MLAB_READER_LEVEL_EN.
module mlab_fifo_reader
  import mlab_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]    wbin_d, wbin_q;
  logic [PW-1:0]    rptr_d, rptr_q;
  logic [PW-1:0]    rgray_d, rgray_q;
  occ_t             buf_d, buf_q;
  logic             infl_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic [WIDTH-1:0] skid_d, skid_q;
  logic             empty, pop, cap, credit_ok;

  mlab_gray2bin #(.W(PW)) u_g2b (
    .gray_i (wptr_gray_sync),
    .bin_o  (wbin_d)
  );

  assign pop   = m_valid & m_ready;
  assign cap   = infl_q;
  assign empty = (rptr_q == wbin_q);

  // A pop this cycle frees a slot for the word requested now.
  assign credit_ok = ({1'b0, buf_q} + {2'b00, infl_q})
                   < (3'(SKID_DEPTH) + {2'b00, pop});

  assign mem_re    = !rst & !empty & credit_ok;
  assign mem_raddr = rptr_q[ADDR_WIDTH-1:0];
  assign rptr_gray = rgray_q;
  assign m_valid   = (buf_q != 2'd0);
  assign m_data    = out_q;

  always_comb begin
    rptr_d  = rptr_q;
    rgray_d = rgray_q;
    if (mem_re) begin
      rptr_d  = rptr_q + 1'b1;
      rgray_d = PW'(bin2gray(32'(rptr_d)));
    end
  end

  always_comb begin
    buf_d  = buf_q;
    out_d  = out_q;
    skid_d = skid_q;
    unique case ({cap, pop})
      2'b10: begin
        if (buf_q == 2'd0) out_d = mem_dout;
        else               skid_d = mem_dout;
        buf_d = buf_q + 2'd1;
      end
      2'b01: begin
        if (buf_q == 2'd2) out_d = skid_q;
        buf_d = buf_q - 2'd1;
      end
      2'b11: begin
        if (buf_q == 2'd2) begin
          out_d  = skid_q;
          skid_d = mem_dout;
        end else begin
          out_d = mem_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      wbin_q  <= '0;
      rptr_q  <= '0;
      rgray_q <= '0;
      buf_q   <= '0;
      infl_q  <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      wbin_q  <= wbin_d;
      rptr_q  <= rptr_d;
      rgray_q <= rgray_d;
      buf_q   <= buf_d;
      infl_q  <= mem_re;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MLAB_READER_LEVEL_EN
  logic [PW-1:0] level_q;

  always_ff @(posedge rclk) begin
    if (rst) level_q <= '0;
    else     level_q <= wbin_q - rptr_q;
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_mlab_fifo_reader.sv
// Randomized bench for mlab_fifo_reader with a queue-based reference.
// Models the MLAB buffer's registered read port behaviourally.
module tb_mlab_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] wptr_gray_sync;
  logic       mem_re;
  logic [4:0] mem_raddr;
  logic [7:0] mem_dout = 8'h00;
  logic [5:0] rptr_gray;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [5:0] level;

  always #5 clk = ~clk;

  mlab_fifo_reader #(.WIDTH(8), .ADDR_WIDTH(5)) dut (
    .rclk           (clk),
    .rst            (rst),
    .wptr_gray_sync (wptr_gray_sync),
    .mem_re         (mem_re),
    .mem_raddr      (mem_raddr),
    .mem_dout       (mem_dout),
    .rptr_gray      (rptr_gray),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .level          (level)
  );

  logic [7:0] mem [32];
  always @(posedge clk) if (mem_re) mem_dout <= mem[mem_raddr];

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int wcnt = 0;
  int consumed = 0;
  bit mon_en = 1'b0;
  bit hold_pend = 1'b0;
  logic [7:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic [7:0] v);
    logic [5:0] w;
    w = 6'(wcnt);
    mem[w[4:0]] = v;
    exp_q.push_back(v);
    wcnt++;
    w = 6'(wcnt);
    wptr_gray_sync = gray(w);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      nedge();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold valid", m_valid, 1'b1);
        chk("hold data", m_data, hold_data);
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra beat", 1, 0);
        else chk("beat", m_data, exp_q.pop_front());
        consumed++;
      end
    end
  end

  initial begin
    int first, last, got, cnt, n;
    logic [5:0] lvl_exp;
    bit seen20, seen00;

    rst = 1'b1;
    m_ready = 1'b0;
    wptr_gray_sync = 6'd5;
    repeat (3) @(posedge clk);
    nedge();
    chk("rst m_valid", m_valid, 0);
    chk("rst mem_re", mem_re, 0);
    chk("rst rptr_gray", rptr_gray, 0);
    chk("rst level", level, 0);
    pedge();
    wptr_gray_sync = 6'd0;
    pedge();
    rst = 1'b0;
    mon_en = 1'b1;
    m_ready = 1'b1;
    repeat (2) pedge();

    push(8'hA5);
    nedge();
    nedge();
    chk("single mem_re", mem_re, 1);
    chk("single raddr", mem_raddr, 0);
    nedge();
    chk("single rptr_gray", rptr_gray, 1);
    nedge();
    chk("single valid", m_valid, 1);
    chk("single data", m_data, 8'hA5);
    nedge();
    chk("single one beat", m_valid, 0);

    pedge();
    for (int k = 0; k < 32; k++) push(8'(k));
`ifdef MLAB_READER_LEVEL_EN
    lvl_exp = 6'd32;
`else
    lvl_exp = 6'd0;
`endif
    first = -1;
    last = -1;
    got = 0;
    for (int i = 0; i < 200 && got < 32; i++) begin
      nedge();
      if (i == 2) chk("stream level", level, lvl_exp);
      if (m_valid && m_ready) begin
        if (first < 0) first = i;
        last = i;
        got++;
      end
    end
    chk("stream beats", got, 32);
    chk("stream no gaps", last - first, 31);
    drain("stream drain");

    pedge();
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) push(8'($urandom));
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      nedge();
      if (mem_re) cnt++;
    end
    chk("bp mem_re count", cnt, 2);
    chk("bp valid", m_valid, 1);
    chk("bp head data", m_data, exp_q[0]);
    pedge();
    m_ready = 1'b1;
    drain("bp drain");

    seen20 = 1'b0;
    seen00 = 1'b0;
    n = 0;
    got = 0;
    while ((got < 80 || exp_q.size() != 0) && n < 4000) begin
      pedge();
      m_ready = ($urandom_range(0, 3) != 0);
      if (got < 80 && $urandom_range(0, 1) == 1) begin
        cnt = $urandom_range(1, 4);
        while (cnt > 0 && got < 80 && (wcnt - consumed) < 32) begin
          push(8'($urandom));
          got++;
          cnt--;
        end
      end
      nedge();
      if (rptr_gray == 6'h20) seen20 = 1'b1;
      if (seen20 && rptr_gray == 6'h00) seen00 = 1'b1;
      n++;
    end
    chk("wrap pushed", got, 80);
    chk("wrap drained", exp_q.size(), 0);
    chk("wrap gray 20", seen20, 1);
    chk("wrap gray 00", seen00, 1);

    pedge();
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(8'($urandom));
    n = 0;
    while (!m_valid && n < 20) begin
      nedge();
      n++;
    end
    chk("midrst saw valid", m_valid, 1);
    pedge();
    rst = 1'b1;
    m_ready = 1'b0;
    mon_en = 1'b0;
    nedge();
    nedge();
    chk("midrst m_valid", m_valid, 0);
    chk("midrst mem_re", mem_re, 0);
    chk("midrst rptr_gray", rptr_gray, 0);
    pedge();
    exp_q.delete();
    wcnt = 0;
    consumed = 0;
    wptr_gray_sync = 6'd0;
    pedge();
    rst = 1'b0;
    mon_en = 1'b1;
    pedge();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(8'(8'h40 + k));
    n = 0;
    nedge();
    while (!mem_re && n < 10) begin
      nedge();
      n++;
    end
    chk("refill mem_re", mem_re, 1);
    chk("refill raddr", mem_raddr, 0);
    drain("refill drain");

    repeat (3) pedge();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
